vga_sincronizador: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/pixel_tick_gen.sv | 29 ++
 rtl/vga_sincronizador.sv | 94 +++++++++
 tb/tb_vga_sincronizador.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants and sync-flag types.
package vga_timing_pkg;

  // Counter width and pixel-clock divider defaults
  localparam int BUS_PIXELES = 10;
  localparam int TICK_DIV    = 4;

  // Horizontal timing in pixels
  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;

  // Inclusive sync-pulse windows (first and last counter value held low)
  localparam int H_SYNC_START = H_DISPLAY + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Registered per-pixel flags that travel together with the counters
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } sync_flags_t;

  // Idle state of the flags: blanked video, both syncs inactive (high)
  localparam sync_flags_t SYNC_FLAGS_IDLE = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate strobe: one-clk pulse every TICK_DIV system clocks.
module pixel_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  // TICK_DIV must be at least 2, so DW is always at least 1
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;

  // Free-running mod-TICK_DIV counter, cleared by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sincronizador.sv
// VGA sync generator: pixel/line counters, registered hsync/vsync/video_on.
module vga_sincronizador #(
  parameter int bus_pixeles = vga_timing_pkg::BUS_PIXELES,
  parameter int TICK_DIV    = vga_timing_pkg::TICK_DIV,
  parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   p_tick,
  output logic [bus_pixeles-1:0] pixel_x,
  output logic [bus_pixeles-1:0] pixel_y,
  output logic                   video_on,
  output logic                   hsync,
  output logic                   vsync
);

  typedef logic [bus_pixeles-1:0] pix_t;

  // Timing limits derived from this instance's parameters
  localparam int   H_TOT      = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int   V_TOT      = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam pix_t H_LAST     = pix_t'(H_TOT - 1);
  localparam pix_t V_LAST     = pix_t'(V_TOT - 1);
  localparam pix_t H_VIS_LAST = pix_t'(H_DISPLAY - 1);
  localparam pix_t V_VIS_LAST = pix_t'(V_DISPLAY - 1);
  localparam pix_t HS_FIRST   = pix_t'(H_DISPLAY + H_FP);
  localparam pix_t HS_LAST    = pix_t'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam pix_t VS_FIRST   = pix_t'(V_DISPLAY + V_FP);
  localparam pix_t VS_LAST    = pix_t'(V_DISPLAY + V_FP + V_SYNC - 1);

  pix_t                        x_next;
  pix_t                        y_next;
  vga_timing_pkg::sync_flags_t flags_next;
  vga_timing_pkg::sync_flags_t flags_q;

  pixel_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Next counter position: advance one pixel per tick, wrapping line and frame
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (p_tick) begin
      if (pixel_x == H_LAST) begin
        x_next = '0;
        if (pixel_y == V_LAST) begin
          y_next = '0;
        end else begin
          y_next = pixel_y + pix_t'(1);
        end
      end else begin
        x_next = pixel_x + pix_t'(1);
      end
    end
  end

  // Decode the next position so the registered flags land with the counters
  always_comb begin
    flags_next          = vga_timing_pkg::SYNC_FLAGS_IDLE;
    flags_next.video_on = (x_next <= H_VIS_LAST) && (y_next <= V_VIS_LAST);
    flags_next.hsync    = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    flags_next.vsync    = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
  end

  // Counter and flag registers, forced to the idle position while in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
      flags_q <= vga_timing_pkg::SYNC_FLAGS_IDLE;
    end else begin
      pixel_x <= x_next;
      pixel_y <= y_next;
      flags_q <= flags_next;
    end
  end

  assign video_on = flags_q.video_on;
  assign hsync    = flags_q.hsync;
  assign vsync    = flags_q.vsync;

endmodule

// File: tb/tb_vga_sincronizador.sv
// Self-checking bench for vga_sincronizador: default timing, fast divider, tiny frame.
module tb_vga_sincronizador;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  logic       a_tick, a_von, a_hs, a_vs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_von, b_hs, b_vs;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_von, c_hs, c_vs;
  logic [9:0] c_x, c_y;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int phase = 0;

  int a_wrap_n = -1, b_wrap_n = -1, c_wrap_n = -1;
  int a_hs_low = 0, b_hs_low = 0, c_vs_low = 0;
  logic [9:0] prev_a_x = '0, prev_b_x = '0, prev_c_y = '0;

  // Default 640x480 timing, 4 clk per pixel
  vga_sincronizador dut_a (
    .clk(clk), .reset(reset), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs)
  );

  // Default timing, 2 clk per pixel
  vga_sincronizador #(.TICK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs)
  );

  // Tiny 17x13 frame so full-frame behaviour fits in a short run
  vga_sincronizador #(
    .TICK_DIV(2), .H_DISPLAY(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_c (
    .clk(clk), .reset(reset), .p_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_von), .hsync(c_hs), .vsync(c_vs)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       tk;
  } exp_t;

  // Expected outputs after nn clk edges since reset release
  function automatic exp_t model(int nn, int td, int hd, int hfp, int hsw, int hbp,
                                 int vd, int vfp, int vsw, int vbp);
    exp_t e;
    int ht, vt, t, px, py;
    ht = hd + hfp + hsw + hbp;
    vt = vd + vfp + vsw + vbp;
    t  = nn / td;
    px = t % ht;
    py = (t / ht) % vt;
    e.x  = 10'(px);
    e.y  = 10'(py);
    e.tk = ((nn % td) == td - 1);
    if (nn == 0) begin
      e.von = 1'b0;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
    end else begin
      e.von = (px < hd) && (py < vd);
      e.hs  = !((px >= hd + hfp) && (px < hd + hfp + hsw));
      e.vs  = !((py >= vd + vfp) && (py < vd + vfp + vsw));
    end
    return e;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d (n=%0d phase=%0d)",
               tag, observed, expected, n, phase);
    end
  endtask

  task automatic checkDut(string nm, logic [9:0] x, logic [9:0] y, logic von,
                          logic hs, logic vs, logic tk, exp_t e);
    checkOutput({nm, ".pixel_x"}, 32'(x), 32'(e.x));
    checkOutput({nm, ".pixel_y"}, 32'(y), 32'(e.y));
    checkOutput({nm, ".video_on"}, 32'(von), 32'(e.von));
    checkOutput({nm, ".hsync"}, 32'(hs), 32'(e.hs));
    checkOutput({nm, ".vsync"}, 32'(vs), 32'(e.vs));
    checkOutput({nm, ".p_tick"}, 32'(tk), 32'(e.tk));
  endtask

  task automatic compareAll();
    checkDut("a", a_x, a_y, a_von, a_hs, a_vs, a_tick, model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    checkDut("b", b_x, b_y, b_von, b_hs, b_vs, b_tick, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    checkDut("c", c_x, c_y, c_von, c_hs, c_vs, c_tick, model(n, 2, 10, 2, 3, 2, 6, 2, 2, 3));
  endtask

  // Hand-computed vectors at the interesting edges
  task automatic directedChecks();
    if (phase == 1) begin
      case (n)
        1:    checkOutput("b_first_tick", 32'(b_tick), 1);
        2:    checkOutput("a_no_tick_yet", 32'(a_tick), 0);
        3:    checkOutput("a_first_tick", 32'(a_tick), 1);
        4:    checkOutput("a_first_step", 32'(a_x), 1);
        271:  checkOutput("c_vs_before", 32'(c_vs), 1);
        272:  checkOutput("c_vs_fall", 32'(c_vs), 0);
        339:  checkOutput("c_vs_last_low", 32'(c_vs), 0);
        340:  checkOutput("c_vs_rise", 32'(c_vs), 1);
        441: begin
          checkOutput("c_end_x", 32'(c_x), 16);
          checkOutput("c_end_y", 32'(c_y), 12);
          checkOutput("c_end_von", 32'(c_von), 0);
        end
        442: begin
          checkOutput("c_wrap_x", 32'(c_x), 0);
          checkOutput("c_wrap_y", 32'(c_y), 0);
          checkOutput("c_wrap_von", 32'(c_von), 1);
          checkOutput("c_wrap_hs", 32'(c_hs), 1);
          checkOutput("c_wrap_vs", 32'(c_vs), 1);
        end
        1311: checkOutput("b_hs_before", 32'(b_hs), 1);
        1312: checkOutput("b_hs_fall", 32'(b_hs), 0);
        1600: begin
          checkOutput("b_line_x", 32'(b_x), 0);
          checkOutput("b_line_y", 32'(b_y), 1);
        end
        2559: checkOutput("a_von_last", 32'(a_von), 1);
        2560: begin
          checkOutput("a_von_fall", 32'(a_von), 0);
          checkOutput("a_x_640", 32'(a_x), 640);
        end
        2623: checkOutput("a_hs_before", 32'(a_hs), 1);
        2624: begin
          checkOutput("a_hs_fall", 32'(a_hs), 0);
          checkOutput("a_x_656", 32'(a_x), 656);
        end
        3007: checkOutput("a_hs_last_low", 32'(a_hs), 0);
        3008: begin
          checkOutput("a_hs_rise", 32'(a_hs), 1);
          checkOutput("a_x_752", 32'(a_x), 752);
        end
        3199: begin
          checkOutput("a_x_799", 32'(a_x), 799);
          checkOutput("a_y_0", 32'(a_y), 0);
        end
        3200: begin
          checkOutput("a_wrap_x", 32'(a_x), 0);
          checkOutput("a_wrap_y", 32'(a_y), 1);
          checkOutput("a_wrap_von", 32'(a_von), 1);
        end
        default: ;
      endcase
    end else if (phase == 2) begin
      case (n)
        3: begin
          checkOutput("restart_x_hold", 32'(a_x), 0);
          checkOutput("restart_tick", 32'(a_tick), 1);
        end
        4: checkOutput("restart_x_step", 32'(a_x), 1);
        default: ;
      endcase
    end
  endtask

  // Event timing measurements over the first line/frame
  task automatic trackEvents();
    if (phase == 1) begin
      if (a_wrap_n < 0 && prev_a_x == 10'd799 && a_x == 10'd0) a_wrap_n = n;
      if (b_wrap_n < 0 && prev_b_x == 10'd799 && b_x == 10'd0) b_wrap_n = n;
      if (c_wrap_n < 0 && prev_c_y == 10'd12 && c_y == 10'd0) c_wrap_n = n;
      if (n <= 3200 && !a_hs) a_hs_low++;
      if (n <= 1600 && !b_hs) b_hs_low++;
      if (n <= 442 && !c_vs) c_vs_low++;
    end
    prev_a_x = a_x;
    prev_b_x = b_x;
    prev_c_y = c_y;
  endtask

  task automatic applyStimulus(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      compareAll();
      directedChecks();
      trackEvents();
    end
  endtask

  initial begin
    $display("[TB] vga_sincronizador bench starting");
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    compareAll();

    reset = 1'b1;
    phase = 1;
    n = 0;
    compareAll();
    applyStimulus(4400);

    checkOutput("a_line_clk", 32'(a_wrap_n), 3200);
    checkOutput("b_line_clk", 32'(b_wrap_n), 1600);
    checkOutput("c_frame_clk", 32'(c_wrap_n), 442);
    checkOutput("a_hs_low_clk", 32'(a_hs_low), 384);
    checkOutput("b_hs_low_clk", 32'(b_hs_low), 192);
    checkOutput("c_vs_low_clk", 32'(c_vs_low), 68);
    checkOutput("a_pos_x_300", 32'(a_x), 300);
    checkOutput("a_pos_y_1", 32'(a_y), 1);

    // Asynchronous reset between clock edges must act immediately
    #2 reset = 1'b0;
    #1;
    n = 0;
    phase = 3;
    compareAll();
    checkOutput("async_x", 32'(a_x), 0);
    checkOutput("async_von", 32'(a_von), 0);
    @(negedge clk);
    compareAll();

    reset = 1'b1;
    phase = 2;
    n = 0;
    applyStimulus(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
